fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-supply side of the 8-bit MCU; it responds to the sequencer's LoadIR/IncPC/LoadPC/SelPC strobes.
- Holds the program counter, the instruction memory and the instruction register.
- Presents Opcode and the immediate operand back to the sequencer and datapath.
- Includes a valid/ready program-load port, used while the core is held in HALT, so the memory can be written before execution.

Parameters:
AW, 4, program-counter / instruction-memory address width (depth 2^AW)
IW, 8, instruction width; [IW-1:IW-4] opcode, [3:0] immediate
HALT_INSN, 8'hF0, instruction forced into IR while programming (opcode 4'b1111 = HALT)

Ports:
CLK  in  1  clock, rising edge
CLB  in  1  asynchronous active-low reset
LoadIR  in  1  load IR from mem[PC]
IncPC  in  1  PC <= PC+1
LoadPC  in  1  PC <= jump target
SelPC  in  1  jump-target select: 1 = reg_target, 0 = Imm
reg_target  in  AW  register-file value for register jumps
prog_en  in  1  1 = program mode (core held)
prog_valid  in  1  write request
prog_ready  out  1  write accepted this cycle when high with prog_valid
prog_addr  in  AW  write address
prog_data  in  IW  write data
Opcode  out  4  IR[IW-1:IW-4]
Imm  out  4  IR[3:0]
PC  out  AW  current program counter
prog_cnt  out  AW+1  number of writes accepted in the current program session

Behaviour:
- Reset (CLB low, async):
  - state=RUN if prog_en is 0, else PROG.
  - PC=0, IR=HALT_INSN, prog_cnt=0.
  - Memory contents are not reset.
- States: RUN, PROG.
  - RUN -> PROG when prog_en=1, sampled at the clock edge.
  - PROG -> RUN when prog_en=0.
- On PROG entry, in the same edge:
  - IR <= HALT_INSN, PC <= 0, prog_cnt <= 0.
  - An in-flight LoadIR/IncPC/LoadPC on that edge is ignored.
- In PROG:
  - prog_ready=1 (registered-state decode, combinational from state).
  - On prog_valid&&prog_ready: mem[prog_addr] <= prog_data; prog_cnt saturates at 2^AW.
  - LoadIR, IncPC and LoadPC are ignored; IR holds HALT_INSN.
- On PROG->RUN edge: PC <= 0, IR <= HALT_INSN. The sequencer's next LoadIR then fetches mem[0].
- In RUN: prog_ready=0 and prog_valid is ignored.
- LoadIR: IR <= mem[PC] at the edge, using the PC value before any same-edge PC update. Opcode/Imm change one cycle after LoadIR.
- PC update priority: LoadPC > IncPC.
  - LoadPC, SelPC=1: PC <= reg_target.
  - LoadPC, SelPC=0: PC <= Imm, zero-extended or truncated to AW.
  - IncPC only: PC <= PC+1, wrapping 2^AW-1 -> 0.
  - Neither: hold.
- LoadIR together with IncPC or LoadPC is legal: IR gets the old-PC word and PC updates.
- Memory read is combinational from the PC register; the write port is used only in PROG, so there is no read/write collision in RUN.
- A write to address X while PC==X in PROG: the write takes effect; the PC value is irrelevant (reset to 0 on exit).

Optional Feature:
- Macro FETCH_BREAK_EN adds:
  - inputs bp_en (1) and bp_addr (AW);
  - output brk_hit (1).
- In RUN, a LoadIR with bp_en=1 and PC==bp_addr:
  - loads HALT_INSN instead of mem[PC];
  - sets brk_hit;
  - forces PC to hold on that edge, even with IncPC asserted.
- brk_hit is sticky; it clears on reset or PROG entry.
- Without the macro these ports do not exist and LoadIR always loads mem[PC].

Test Plan:
- Reset with prog_en=0 -> PC=0, Opcode=4'hF, Imm=0, prog_ready=0, prog_cnt=0.
- prog_en=1, write 0:8'h1A, 1:8'h73, 2:8'hF0 with prog_valid held 3 cycles, then prog_en=0 -> prog_cnt=3; LoadIR gives Opcode=1, Imm=A; IncPC+LoadIR then gives Opcode=7, Imm=3, PC=2.
- PC=15, IncPC -> PC=0 (wrap). LoadPC+IncPC with SelPC=0, Imm=5 -> PC=5 (LoadPC wins). SelPC=1, reg_target=9 -> PC=9.
- Assert prog_en mid-run with LoadIR and IncPC high at PC=6 -> PC=0, IR=8'hF0; memory unchanged except subsequent writes; prog_valid during RUN is not written.
- Async CLB pulse between edges while in PROG with prog_valid high -> outputs reset immediately; no write of that beat occurs; state = PROG if prog_en still 1.
- FETCH_BREAK_EN: bp_en=1, bp_addr=2, run from 0 -> on LoadIR at PC=2: Opcode=F, brk_hit=1, PC stays 2. Re-entering PROG clears brk_hit.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, instruction memory and instruction register
// for the 8-bit MCU core.
// The sequencer drives the LoadIR/IncPC/LoadPC/SelPC strobes.
// A valid/ready load port writes the memory while the core is held in PROG.
// Optional breakpoint logic is compiled in when FETCH_BREAK_EN is defined.
module fetch_unit #(
    parameter int unsigned     AW        = 4,
    parameter int unsigned     IW        = 8,
    parameter logic [IW-1:0]   HALT_INSN = 8'hF0
) (
    input  logic          CLK,
    input  logic          CLB,
    input  logic          LoadIR,
    input  logic          IncPC,
    input  logic          LoadPC,
    input  logic          SelPC,
    input  logic [AW-1:0] reg_target,
    input  logic          prog_en,
    input  logic          prog_valid,
    output logic          prog_ready,
    input  logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    output logic [3:0]    Opcode,
    output logic [3:0]    Imm,
    output logic [AW-1:0] PC,
    output logic [AW:0]   prog_cnt
`ifdef FETCH_BREAK_EN
    ,
    input  logic          bp_en,
    input  logic [AW-1:0] bp_addr,
    output logic          brk_hit
`endif
);

    typedef enum logic {
        RUN  = 1'b0,
        PROG = 1'b1
    } state_t;

    localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_pc;
    logic [IW-1:0] r_ir;
    logic [AW:0]   r_cnt;
    logic [IW-1:0] r_mem [0:(1<<AW)-1];

    logic          w_prog_entry;
    logic          w_prog_exit;
    logic          w_run_act;
    logic          w_wr;
    logic          w_brk;
    logic [AW-1:0] w_imm_ext;

    // State register; the reset state follows prog_en so a held core comes up in PROG
    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            r_state <= prog_en ? PROG : RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and mode decode
    always_comb begin
        w_state_nxt  = r_state;
        prog_ready   = 1'b0;
        w_prog_entry = 1'b0;
        w_prog_exit  = 1'b0;
        w_run_act    = 1'b0;
        case (r_state)
            RUN: begin
                if (prog_en) begin
                    w_state_nxt  = PROG;
                    w_prog_entry = 1'b1;
                end else begin
                    w_run_act    = 1'b1;
                end
            end
            PROG: begin
                prog_ready = 1'b1;
                if (!prog_en) begin
                    w_state_nxt = RUN;
                    w_prog_exit = 1'b1;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    assign w_wr      = prog_ready && prog_valid;
    assign w_imm_ext = AW'(r_ir[3:0]);

`ifdef FETCH_BREAK_EN
    logic r_brk;

    assign w_brk   = w_run_act && LoadIR && bp_en && (r_pc == bp_addr);
    assign brk_hit = r_brk;

    // Sticky breakpoint flag, cleared on reset or entry to PROG
    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            r_brk <= 1'b0;
        end else if (w_prog_entry) begin
            r_brk <= 1'b0;
        end else if (w_brk) begin
            r_brk <= 1'b1;
        end
    end
`else
    assign w_brk = 1'b0;
`endif

    // Instruction memory write port; contents are deliberately not reset
    always_ff @(posedge CLK) begin
        if (w_wr) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    // PC and IR: mode transitions park the core, RUN applies the sequencer strobes
    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            r_pc <= '0;
            r_ir <= HALT_INSN;
        end else if (w_prog_entry || w_prog_exit || (r_state == PROG)) begin
            r_pc <= '0;
            r_ir <= HALT_INSN;
        end else if (w_run_act) begin
            if (LoadIR) begin
                r_ir <= w_brk ? HALT_INSN : r_mem[r_pc];
            end
            if (!w_brk) begin
                if (LoadPC) begin
                    r_pc <= SelPC ? reg_target : w_imm_ext;
                end else if (IncPC) begin
                    r_pc <= r_pc + AW'(1);
                end
            end
        end
    end

    // Count of writes accepted in the current program session, saturating at the memory depth
    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            r_cnt <= '0;
        end else if (w_prog_entry) begin
            r_cnt <= '0;
        end else if (w_wr && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + (AW+1)'(1);
        end
    end

    assign Opcode   = r_ir[IW-1:IW-4];
    assign Imm      = r_ir[3:0];
    assign PC       = r_pc;
    assign prog_cnt = r_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with hand-computed expected values.
// The breakpoint checks are compiled in only when FETCH_BREAK_EN is defined.
module tb_fetch_unit;

    logic       CLK = 1'b0;
    logic       CLB;
    logic       LoadIR, IncPC, LoadPC, SelPC;
    logic [3:0] reg_target;
    logic       prog_en, prog_valid, prog_ready;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic [3:0] Opcode, Imm, PC;
    logic [4:0] prog_cnt;
`ifdef FETCH_BREAK_EN
    logic       bp_en;
    logic [3:0] bp_addr;
    logic       brk_hit;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    fetch_unit #(.AW(4), .IW(8), .HALT_INSN(8'hF0)) dut (
        .CLK        (CLK),
        .CLB        (CLB),
        .LoadIR     (LoadIR),
        .IncPC      (IncPC),
        .LoadPC     (LoadPC),
        .SelPC      (SelPC),
        .reg_target (reg_target),
        .prog_en    (prog_en),
        .prog_valid (prog_valid),
        .prog_ready (prog_ready),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .Opcode     (Opcode),
        .Imm        (Imm),
        .PC         (PC),
        .prog_cnt   (prog_cnt)
`ifdef FETCH_BREAK_EN
        ,
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .brk_hit    (brk_hit)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic strobes(input logic ld_ir, input logic inc, input logic ld_pc,
                           input logic sel, input logic [3:0] tgt);
        LoadIR     = ld_ir;
        IncPC      = inc;
        LoadPC     = ld_pc;
        SelPC      = sel;
        reg_target = tgt;
    endtask

    task automatic prog_write(input logic [3:0] a, input logic [7:0] d);
        prog_valid = 1'b1;
        prog_addr  = a;
        prog_data  = d;
        step();
        prog_valid = 1'b0;
    endtask

    initial begin
        CLB = 1'b0;
        strobes(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        prog_en    = 1'b0;
        prog_valid = 1'b0;
        prog_addr  = 4'h0;
        prog_data  = 8'h00;
`ifdef FETCH_BREAK_EN
        bp_en   = 1'b0;
        bp_addr = 4'h0;
`endif
        #12;
        chk("rst_pc",     32'(PC),         32'h0);
        chk("rst_op",     32'(Opcode),     32'hF);
        chk("rst_imm",    32'(Imm),        32'h0);
        chk("rst_ready",  32'(prog_ready), 32'h0);
        chk("rst_cnt",    32'(prog_cnt),   32'h0);
        CLB = 1'b1;
        step();

        // Enter PROG and load the program
        prog_en = 1'b1;
        step();
        chk("prog_ready", 32'(prog_ready), 32'h1);
        prog_valid = 1'b1;
        prog_addr = 4'h0; prog_data = 8'h1A; step();
        prog_addr = 4'h1; prog_data = 8'h73; step();
        prog_addr = 4'h2; prog_data = 8'hF0; step();
        prog_valid = 1'b0;
        chk("cnt3", 32'(prog_cnt), 32'h3);
        prog_write(4'h3, 8'h25);
        prog_write(4'h4, 8'h36);
        prog_write(4'h5, 8'h47);
        prog_write(4'h6, 8'h58);
        chk("cnt7", 32'(prog_cnt), 32'h7);
        prog_en = 1'b0;
        step();
        chk("exit_cnt",   32'(prog_cnt),   32'h7);
        chk("exit_pc",    32'(PC),         32'h0);
        chk("exit_op",    32'(Opcode),     32'hF);
        chk("exit_ready", 32'(prog_ready), 32'h0);

        // Sequential fetch
        strobes(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        step();
        chk("f0_op",  32'(Opcode), 32'h1);
        chk("f0_imm", 32'(Imm),    32'hA);
        chk("f0_pc",  32'(PC),     32'h1);
        step();
        chk("f1_op",  32'(Opcode), 32'h7);
        chk("f1_imm", 32'(Imm),    32'h3);
        chk("f1_pc",  32'(PC),     32'h2);

        // prog_valid in RUN must be ignored
        strobes(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        prog_valid = 1'b1; prog_addr = 4'h0; prog_data = 8'hEE;
        #1;
        chk("run_ready", 32'(prog_ready), 32'h0);
        step();
        prog_valid = 1'b0;
        chk("run_cnt", 32'(prog_cnt), 32'h7);

        // Jumps and wrap
        strobes(1'b0, 1'b0, 1'b1, 1'b1, 4'h3); step();
        chk("jr3", 32'(PC), 32'h3);
        strobes(1'b1, 1'b0, 1'b0, 1'b0, 4'h0); step();
        chk("ir25_op",  32'(Opcode), 32'h2);
        chk("ir25_imm", 32'(Imm),    32'h5);
        strobes(1'b0, 1'b0, 1'b1, 1'b1, 4'hF); step();
        chk("jr15", 32'(PC), 32'hF);
        strobes(1'b0, 1'b1, 1'b0, 1'b0, 4'h0); step();
        chk("wrap", 32'(PC), 32'h0);
        strobes(1'b0, 1'b1, 1'b1, 1'b0, 4'h0); step();
        chk("jimm_wins", 32'(PC), 32'h5);
        strobes(1'b0, 1'b0, 1'b1, 1'b1, 4'h9); step();
        chk("jr9", 32'(PC), 32'h9);
        strobes(1'b0, 1'b0, 1'b0, 1'b0, 4'h0); step();
        chk("hold", 32'(PC), 32'h9);

        // PROG entry mid-run with strobes active
        strobes(1'b0, 1'b0, 1'b1, 1'b1, 4'h6); step();
        chk("jr6", 32'(PC), 32'h6);
        strobes(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        prog_en = 1'b1;
        step();
        chk("entry_pc",    32'(PC),         32'h0);
        chk("entry_op",    32'(Opcode),     32'hF);
        chk("entry_imm",   32'(Imm),        32'h0);
        chk("entry_cnt",   32'(prog_cnt),   32'h0);
        chk("entry_ready", 32'(prog_ready), 32'h1);
        step();
        chk("prog_ignore_pc", 32'(PC),     32'h0);
        chk("prog_ignore_op", 32'(Opcode), 32'hF);
        strobes(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        prog_write(4'h4, 8'hC4);
        chk("cnt1", 32'(prog_cnt), 32'h1);
        prog_en = 1'b0;
        step();

        strobes(1'b1, 1'b0, 1'b0, 1'b0, 4'h0); step();
        chk("mem0_op",  32'(Opcode), 32'h1);
        chk("mem0_imm", 32'(Imm),    32'hA);
        strobes(1'b0, 1'b0, 1'b1, 1'b1, 4'h4); step();
        strobes(1'b1, 1'b0, 1'b0, 1'b0, 4'h0); step();
        chk("mem4_op",  32'(Opcode), 32'hC);
        chk("mem4_imm", 32'(Imm),    32'h4);
        strobes(1'b0, 1'b0, 1'b1, 1'b1, 4'h6); step();
        strobes(1'b1, 1'b0, 1'b0, 1'b0, 4'h0); step();
        chk("mem6_op",  32'(Opcode), 32'h5);
        chk("mem6_imm", 32'(Imm),    32'h8);

        // Asynchronous reset pulse between edges while in PROG
        strobes(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        prog_en = 1'b1;
        step();
        prog_write(4'h7, 8'hBB);
        chk("pre_rst_cnt", 32'(prog_cnt), 32'h1);
        prog_valid = 1'b1; prog_addr = 4'h5; prog_data = 8'hDD;
        #3 CLB = 1'b0;
        #1;
        chk("arst_cnt",   32'(prog_cnt),   32'h0);
        chk("arst_pc",    32'(PC),         32'h0);
        chk("arst_op",    32'(Opcode),     32'hF);
        chk("arst_ready", 32'(prog_ready), 32'h1);
        prog_valid = 1'b0;
        #1 CLB = 1'b1;
        step();
        chk("arst_nowr_cnt", 32'(prog_cnt), 32'h0);
        prog_en = 1'b0;
        step();
        strobes(1'b0, 1'b0, 1'b1, 1'b1, 4'h5); step();
        strobes(1'b1, 1'b0, 1'b0, 1'b0, 4'h0); step();
        chk("mem5_op",  32'(Opcode), 32'h4);
        chk("mem5_imm", 32'(Imm),    32'h7);
        strobes(1'b0, 1'b0, 1'b1, 1'b1, 4'h7); step();
        strobes(1'b1, 1'b0, 1'b0, 1'b0, 4'h0); step();
        chk("mem7_op",  32'(Opcode), 32'hB);
        chk("mem7_imm", 32'(Imm),    32'hB);

`ifdef FETCH_BREAK_EN
        // Breakpoint at address 2
        bp_en = 1'b1; bp_addr = 4'h2;
        strobes(1'b0, 1'b0, 1'b1, 1'b1, 4'h0); step();
        chk("bp_idle", 32'(brk_hit), 32'h0);
        strobes(1'b1, 1'b1, 1'b0, 1'b0, 4'h0); step();
        step();
        chk("bp_pre_pc",  32'(PC),      32'h2);
        chk("bp_pre_hit", 32'(brk_hit), 32'h0);
        step();
        chk("bp_op",  32'(Opcode),  32'hF);
        chk("bp_imm", 32'(Imm),     32'h0);
        chk("bp_hit", 32'(brk_hit), 32'h1);
        chk("bp_pc",  32'(PC),      32'h2);
        strobes(1'b0, 1'b1, 1'b0, 1'b0, 4'h0); step();
        chk("bp_sticky", 32'(brk_hit), 32'h1);
        chk("bp_inc_pc", 32'(PC),      32'h3);
        strobes(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        prog_en = 1'b1;
        step();
        chk("bp_clear", 32'(brk_hit), 32'h0);
        prog_en = 1'b0;
        bp_en   = 1'b0;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
